fwd_producer_pipe: RTL and testbench

Producer side of the EX-stage operand forwarding network. It holds the EX/MEM and MEM/WB pipeline registers and presents their destination register and result to the EX forwarding muxes as the "EX-previous" and "MEM-previous" sources. It turns the load-use stop from the EX muxes into bubbles and holds the pipeline while a load waits for memory data. It also drives the register-file write port.

---
 rtl/fwd_producer_pipe.sv | 177 +++++++++++++++++
 tb/tb_fwd_producer_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_producer_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fwd_producer_pipe
//
// Producer side of the EX-stage operand forwarding network. Holds the EX/MEM
// and MEM/WB pipeline registers and exposes them to the EX forwarding muxes as
// the "EX-previous" (expro_*) and "MEM-previous" (mempro_*) sources. A
// load-use stop from the muxes becomes a bubble in EX/MEM. A load sitting in
// EX/MEM freezes the pipeline (hold_req) until memory returns its data. The
// MEM/WB register drives the register-file write port.
//
// Optional feature (compile-time macro FWD_LOAD_TIMEOUT_EN):
//   defined   - a load waiting MAX_WAIT cycles is completed with data 0 and the
//               sticky load_err flag is raised.
//   undefined - a load waits for mem_rvalid indefinitely; load_err is tied 0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_valid/ex_rd/ex_result/
//   ex_reg_write/ex_is_load     instruction currently in EX
//   stall_in                    load-use stop from the EX forwarding muxes
//   mem_req/mem_addr            load request to data memory
//   mem_rdata/mem_rvalid        load data returned from data memory
//   hold_req                    freeze PC/IF/ID/ID-EX this cycle
//   expro_addr/data/is_load     EX/MEM forwarding source
//   mempro_addr/data            MEM/WB forwarding source
//   wb_we/wb_addr/wb_data       register-file write port
//   load_err                    sticky load-timeout flag
// -----------------------------------------------------------------------------
module fwd_producer_pipe #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_reg_write,
    input  logic            ex_is_load,
    input  logic            stall_in,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            hold_req,
    output logic [AW-1:0]   expro_addr,
    output logic [XLEN-1:0] expro_data,
    output logic            expro_is_load,
    output logic [AW-1:0]   mempro_addr,
    output logic [XLEN-1:0] mempro_data,
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            load_err
);

    // The timeout needs at least one wait cycle to be meaningful.
    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("fwd_producer_pipe: MAX_WAIT must be at least 1");
    end

    // EX/MEM register
    logic [AW-1:0]   em_rd;
    logic            em_we;
    logic            em_load;
    logic [XLEN-1:0] em_result;

    // MEM/WB register
    logic [AW-1:0]   mw_rd;
    logic            mw_we;
    logic [XLEN-1:0] mw_data;

    logic            hold;
    logic            timeout;
    logic [XLEN-1:0] mw_data_next;

`ifdef FWD_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;
    logic          load_err_q;

    // The timeout cycle behaves like a data return: hold drops and the load
    // retires with zero data on that edge.
    assign timeout = em_load & ~mem_rvalid & (wait_cnt == CW'(MAX_WAIT));
    assign hold    = em_load & ~mem_rvalid & ~timeout;

    // Counts consecutive held cycles; any non-held cycle restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            load_err_q <= 1'b0;
        end else begin
            wait_cnt <= hold ? wait_cnt + 1'b1 : '0;
            if (timeout) begin
                load_err_q <= 1'b1;
            end
        end
    end

    assign load_err = load_err_q;
`else
    assign timeout  = 1'b0;
    assign hold     = em_load & ~mem_rvalid;
    assign load_err = 1'b0;
`endif

    // mem_rvalid only matters while a load occupies EX/MEM; same-cycle data
    // completes the load without any hold.
    always_comb begin
        mw_data_next = em_result;
        if (em_load) begin
            mw_data_next = timeout ? '0 : mem_rdata;
        end
    end

    // EX/MEM: hold wins over stall_in so a waiting load is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_rd     <= '0;
            em_we     <= 1'b0;
            em_load   <= 1'b0;
            em_result <= '0;
        end else if (hold) begin
            em_rd     <= em_rd;
            em_we     <= em_we;
            em_load   <= em_load;
            em_result <= em_result;
        end else if (stall_in || !ex_valid) begin
            em_rd     <= '0;
            em_we     <= 1'b0;
            em_load   <= 1'b0;
            em_result <= '0;
        end else begin
            em_rd     <= ex_rd;
            em_we     <= ex_reg_write;
            em_load   <= ex_is_load;
            em_result <= ex_result;
        end
    end

    // MEM/WB: receives a bubble every cycle a load is still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_rd   <= '0;
            mw_we   <= 1'b0;
            mw_data <= '0;
        end else if (hold) begin
            mw_rd   <= '0;
            mw_we   <= 1'b0;
            mw_data <= '0;
        end else begin
            mw_rd   <= em_rd;
            mw_we   <= em_we;
            mw_data <= mw_data_next;
        end
    end

    assign hold_req      = hold;
    assign mem_req       = em_load;
    assign mem_addr      = em_result;

    // x0 is never exposed as a forwarding source or a register-file write.
    assign expro_addr    = (em_we && em_rd != '0) ? em_rd : '0;
    assign expro_data    = em_result;
    assign expro_is_load = em_load;

    assign mempro_addr   = (mw_we && mw_rd != '0) ? mw_rd : '0;
    assign mempro_data   = mw_data;

    assign wb_we         = mw_we & (mw_rd != '0);
    assign wb_addr       = mw_rd;
    assign wb_data       = mw_data;

endmodule

// File: tb/tb_fwd_producer_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fwd_producer_pipe
//
// Directed scenarios followed by a randomized run of fwd_producer_pipe. A
// small reference model tracks the instruction held in each pipeline slot and
// the number of cycles the current load has waited; every cycle all outputs
// are compared against it. Honours FWD_LOAD_TIMEOUT_EN like the design.
// -----------------------------------------------------------------------------
module tb_fwd_producer_pipe;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int MAX_WAIT = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            ex_reg_write;
    logic            ex_is_load;
    logic            stall_in;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;
    logic            hold_req;
    logic [AW-1:0]   expro_addr;
    logic [XLEN-1:0] expro_data;
    logic            expro_is_load;
    logic [AW-1:0]   mempro_addr;
    logic [XLEN-1:0] mempro_data;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            load_err;

    int checks = 0;
    int errors = 0;
    int hold_seen = 0;

    // Reference model: the instruction in each slot plus load wait bookkeeping.
    typedef struct {
        logic [AW-1:0]   rd;
        logic            we;
        logic            ld;
        logic [XLEN-1:0] val;
    } instr_t;

    localparam instr_t BUBBLE = '{rd: '0, we: 1'b0, ld: 1'b0, val: '0};

    instr_t m_em;
    instr_t m_mw;
    int     m_wait;
    logic   m_err;

    fwd_producer_pipe #(
        .XLEN(XLEN), .AW(AW), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .stall_in(stall_in),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hold_req(hold_req),
        .expro_addr(expro_addr), .expro_data(expro_data),
        .expro_is_load(expro_is_load),
        .mempro_addr(mempro_addr), .mempro_data(mempro_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic load_timed_out();
`ifdef FWD_LOAD_TIMEOUT_EN
        return m_em.ld && !mem_rvalid && (m_wait == MAX_WAIT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic load_waiting();
        return m_em.ld && !mem_rvalid && !load_timed_out();
    endfunction

    task automatic model_reset();
        m_em   = BUBBLE;
        m_mw   = BUBBLE;
        m_wait = 0;
        m_err  = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic step_model();
        logic waiting;
        logic timed_out;
        if (!rst_n) begin
            model_reset();
            return;
        end
        waiting   = load_waiting();
        timed_out = load_timed_out();
        if (waiting) begin
            m_mw   = BUBBLE;
            m_wait = m_wait + 1;
        end else begin
            m_mw     = m_em;
            if (m_em.ld) m_mw.val = timed_out ? '0 : mem_rdata;
            m_mw.ld  = 1'b0;
            m_wait   = 0;
            if (stall_in || !ex_valid) begin
                m_em = BUBBLE;
            end else begin
                m_em = '{rd: ex_rd, we: ex_reg_write, ld: ex_is_load, val: ex_result};
            end
        end
        if (timed_out) m_err = 1'b1;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic checkOutput();
        logic wr_em;
        logic wr_mw;
        wr_em = m_em.we && (m_em.rd != 0);
        wr_mw = m_mw.we && (m_mw.rd != 0);
        if (hold_req === 1'b1) hold_seen++;
        chk("hold_req",      hold_req,      load_waiting());
        chk("mem_req",       mem_req,       m_em.ld);
        chk("mem_addr",      mem_addr,      m_em.val);
        chk("expro_addr",    expro_addr,    wr_em ? m_em.rd : '0);
        chk("expro_data",    expro_data,    m_em.val);
        chk("expro_is_load", expro_is_load, m_em.ld);
        chk("mempro_addr",   mempro_addr,   wr_mw ? m_mw.rd : '0);
        chk("mempro_data",   mempro_data,   m_mw.val);
        chk("wb_we",         wb_we,         wr_mw);
        chk("wb_addr",       wb_addr,       m_mw.rd);
        chk("wb_data",       wb_data,       m_mw.val);
        chk("load_err",      load_err,      m_err);
    endtask

    // One clock cycle: drive at the falling edge, check, then cross the edge.
    task automatic applyStimulus(
        input logic            valid,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] res,
        input logic            we,
        input logic            ld,
        input logic            stall,
        input logic            rvalid,
        input logic [XLEN-1:0] rdata
    );
        @(negedge clk);
        ex_valid     = valid;
        ex_rd        = rd;
        ex_result    = res;
        ex_reg_write = we;
        ex_is_load   = ld;
        stall_in     = stall;
        mem_rvalid   = rvalid;
        mem_rdata    = rdata;
        #1;
        checkOutput();
        @(posedge clk);
        step_model();
    endtask

    task automatic idle(input logic rvalid);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rvalid, '0);
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_valid     = 1'b0;
        ex_rd        = '0;
        ex_result    = '0;
        ex_reg_write = 1'b0;
        ex_is_load   = 1'b0;
        stall_in     = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op through both forwarding stages
        $display("[TB] ALU op");
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("alu_expro_addr", expro_addr, 5);
        chk("alu_expro_data", expro_data, 32'h11);
        idle(1'b0);
        #1;
        chk("alu_mempro_addr", mempro_addr, 5);
        chk("alu_wb_we",       wb_we,       1);
        chk("alu_wb_addr",     wb_addr,     5);
        chk("alu_wb_data",     wb_data,     32'h11);
        idle(1'b0);

        // Load with a 3-cycle wait
        $display("[TB] load with wait");
        applyStimulus(1'b1, 5'd7, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        hold_seen = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678);
            #1;
            chk("ld_mem_req",       mem_req,     1);
            chk("ld_mem_addr",      mem_addr,    32'h100);
            chk("ld_mempro_bubble", mempro_addr, 0);
        end
        chk("ld_hold_cycles", hold_seen, 3);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        #1;
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_addr", wb_addr, 7);
        chk("ld_wb_we",   wb_we,   1);
        idle(1'b0);

        // Load with data in the same cycle: no hold
        applyStimulus(1'b1, 5'd8, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        hold_seen = 0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5);
        #1;
        chk("ld0_hold_cycles", hold_seen, 0);
        chk("ld0_wb_data",     wb_data,   32'hA5A5A5A5);

        // Load-use stop turns the EX instruction into a bubble
        $display("[TB] stall");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("stall_expro_addr", expro_addr,    0);
        chk("stall_expro_load", expro_is_load, 0);
        idle(1'b0);
        #1;
        chk("stall_wb_we", wb_we, 0);

        // Writes to x0 stay invisible
        $display("[TB] x0 write");
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("x0_expro_addr", expro_addr, 0);
        chk("x0_expro_data", expro_data, 32'h55);
        idle(1'b0);
        #1;
        chk("x0_mempro_addr", mempro_addr, 0);
        chk("x0_wb_we",       wb_we,       0);
        idle(1'b0);

        // Long wait: persists without the timeout, retires at MAX_WAIT with it
        $display("[TB] long load wait");
        applyStimulus(1'b1, 5'd7, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        hold_seen = 0;
`ifdef FWD_LOAD_TIMEOUT_EN
        for (int i = 0; i < MAX_WAIT + 1; i++) idle(1'b0);
        #1;
        chk("to_hold_cycles", hold_seen, MAX_WAIT);
        chk("to_wb_data",     wb_data,   0);
        chk("to_wb_we",       wb_we,     1);
        chk("to_load_err",    load_err,  1);
        idle(1'b0);
        idle(1'b0);
        #1;
        chk("to_load_err_sticky", load_err, 1);
`else
        for (int i = 0; i < 20; i++) idle(1'b0);
        chk("wait_hold_cycles", hold_seen, 20);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE0001);
        #1;
        chk("wait_wb_data",  wb_data,  32'hCAFE0001);
        chk("wait_load_err", load_err, 0);
`endif

        // Reset in the middle of a load wait
        $display("[TB] reset mid-wait");
        applyStimulus(1'b1, 5'd9, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput();
        chk("rst_mem_req",  mem_req,  0);
        chk("rst_hold_req", hold_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(1'b0);
        #1;
        chk("rst_alu_wb_addr", wb_addr, 4);
        chk("rst_alu_wb_data", wb_data, 32'h44);

        // Randomized traffic
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(
                $urandom_range(0, 3) != 0,
                AW'($urandom_range(0, 31)),
                $urandom,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) == 0,
                $urandom
            );
        end
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
